hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the pipelined RISC-V core, sitting beside the ID stage.
//  Generalises the load-use stall to memories with a configurable multi-cycle load latency.
//  A per-register countdown scoreboard tracks in-flight load destinations.
//  Also produces EX-stage and decode-stage forwarding selects from EX/MEM and MEM/WB.
// PARAMETERS
//  REG_AW    5  register address width; NUM_REGS = 2**REG_AW
//  LOAD_LAT  1  cycles after a load leaves EX before its data is forwardable (>=1)
//  CNT_W     $clog2(LOAD_LAT+1)  scoreboard counter width (derived, do not override)
// PORTS
//  clk                 in   1      clock, rising edge
//  reset               in   1      asynchronous, active-high
//  if_id_rs1/rs2       in   REG_AW source registers of instruction in ID
//  if_id_use_rs1/rs2   in   1      ID instruction actually reads rs1/rs2
//  id_ex_valid         in   1      EX holds a real (non-bubble) instruction
//  id_ex_mem_read      in   1      EX instruction is a load
//  id_ex_rd            in   REG_AW EX destination
//  id_ex_rs1/rs2       in   REG_AW EX sources
//  ex_mem_rd, mem_wb_rd in  REG_AW destinations in MEM and WB
//  ex_mem_reg_write, mem_wb_reg_write in 1 write enables in MEM and WB
//  stall               out  1      hold PC and IF/ID, inject bubble into ID/EX
//  forward_a/b         out  2      EX operand select: 00 reg, 01 EX/MEM, 10 MEM/WB
//  forward_rs1_decode/forward_rs2_decode out 2  same encoding for ID-stage operands
//  stall_count         out  32     stalled-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Scoreboard: cnt[r] (CNT_W bits) for r = 1..NUM_REGS-1; x0 is never tracked.
//  - Reset (async): all cnt = 0, stall_count = 0. Outputs are combinational from state.
//    With no live load in EX, stall = 0 and all forward selects = 00.
//  - Issue: at each clock edge, if id_ex_valid && id_ex_mem_read && id_ex_rd != 0,
//    then cnt[id_ex_rd] <= LOAD_LAT-1.
//  - All other nonzero cnt decrement by 1 each cycle, independent of stall.
//  - Issue to a reg with nonzero cnt reloads it; issue wins over decrement on that reg.
//  - hit(s) = use_s && s != 0 &&
//      ( (id_ex_valid && id_ex_mem_read && id_ex_rd == s) || cnt[s] != 0 ).
//  - stall = hit(if_id_rs1) | hit(if_id_rs2).
//    The stall is LOAD_LAT cycles long per dependent load.
//    LOAD_LAT=1 gives the classic 1-bubble load-use stall.
//  - Back-to-back loads to distinct regs are tracked independently.
//    The stall lasts until the last awaited counter clears.
//  - Forwarding (combinational), per EX source s:
//    - 01 if ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == s;
//    - else 10 if mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == s;
//    - else 00. EX/MEM has priority (youngest value).
//  - Decode selects use the identical rule on if_id_rs1/rs2.
//    They are gated by use_s; an unused source gives 00.
//  - Reset mid-stall: counters clear immediately and stall drops in the same cycle
//    (asynchronous).
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    stall_count increments on every cycle with stall = 1 and saturates at 32'hFFFF_FFFF.
//  HAZARD_PERF_EN undefined:
//    no counter logic; stall_count is tied to 32'd0.
//  All other behaviour is identical.
// TESTING
//  1. LOAD_LAT=1: lw x5 in EX, add x6,x5,x1 in ID
//     -> stall=1 for 1 cycle; in the next EX, forward_a=10.
//  2. LOAD_LAT=3: lw x7 in EX, then consumer of x7 held in ID
//     -> stall high exactly 3 cycles, cnt[7] goes 2,1,0.
//  3. Load to x0 with use of x0 -> stall=0 and all forward selects 00.
//  4. ex_mem_rd=mem_wb_rd=x3, both writing, id_ex_rs1=x3 -> forward_a=01.
//     With ex_mem_reg_write=0 -> forward_a=10.
//  5. LOAD_LAT=3: lw x4, then lw x4 one cycle later -> counter reloads to 2.
//     A consumer of x4 stalls until 3 cycles after the second load.
//  6. reset asserted while stall=1 -> stall=0 asynchronously, cnt all 0, stall_count=0.
//     With HAZARD_PERF_EN, also check stall_count after scenario 2 equals 3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit with per-register countdown scoreboard and EX/decode forwarding selects.
// Optional stalled-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] if_id_rs1,
   input  logic [REG_AW-1:0] if_id_rs2,
   input  logic              if_id_use_rs1,
   input  logic              if_id_use_rs2,
   input  logic              id_ex_valid,
   input  logic              id_ex_mem_read,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic [REG_AW-1:0] id_ex_rs1,
   input  logic [REG_AW-1:0] id_ex_rs2,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic [REG_AW-1:0] mem_wb_rd,
   input  logic              ex_mem_reg_write,
   input  logic              mem_wb_reg_write,
   output logic              stall,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic [1:0]        forward_rs1_decode,
   output logic [1:0]        forward_rs2_decode,
   output logic [31:0]       stall_count
);

   localparam int NUM_REGS = 2 ** REG_AW;
   localparam int CNT_W    = $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

   logic [CNT_W-1:0]    cnt_q [1:NUM_REGS-1];
   logic [CNT_W-1:0]    cnt_d [1:NUM_REGS-1];
   logic [NUM_REGS-1:0] busy_s;
   logic                issue_s;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              mem_we,
      input logic [REG_AW-1:0] mem_rd,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
         sel = 2'b01;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign issue_s   = id_ex_valid && id_ex_mem_read && (id_ex_rd != '0);
   assign busy_s[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_busy
      assign busy_s[r] = (cnt_q[r] != '0);
   end

   // Counter next state: a new load reloads its destination, otherwise live counters count down.
   always_comb begin
      for (int r = 1; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (issue_s && (id_ex_rd == REG_AW'(r))) begin
            cnt_d[r] = CNT_LOAD;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end else begin
            cnt_d[r] = cnt_q[r];
         end
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Hazard detection and forwarding selects; the load still in EX counts as in flight.
   always_comb begin
      logic hit1;
      logic hit2;
      hit1 = 1'b0;
      hit2 = 1'b0;
      if (if_id_use_rs1 && (if_id_rs1 != '0)) begin
         hit1 = (id_ex_valid && id_ex_mem_read && (id_ex_rd == if_id_rs1)) || busy_s[if_id_rs1];
      end else begin
         hit1 = 1'b0;
      end
      if (if_id_use_rs2 && (if_id_rs2 != '0)) begin
         hit2 = (id_ex_valid && id_ex_mem_read && (id_ex_rd == if_id_rs2)) || busy_s[if_id_rs2];
      end else begin
         hit2 = 1'b0;
      end
      stall     = hit1 | hit2;
      forward_a = fwd_sel(id_ex_rs1, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
      forward_b = fwd_sel(id_ex_rs2, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
      if (if_id_use_rs1) begin
         forward_rs1_decode = fwd_sel(if_id_rs1, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
      end else begin
         forward_rs1_decode = 2'b00;
      end
      if (if_id_use_rs2) begin
         forward_rs2_decode = fwd_sel(if_id_rs2, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
      end else begin
         forward_rs2_decode = 2'b00;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Saturating count of stalled cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: LOAD_LAT=1 and LOAD_LAT=3 instances on shared stimulus, checked
// against a ready-time model (a load issued at cycle t blocks its register until t+LOAD_LAT).
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd, id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
   logic       if_id_use_rs1, if_id_use_rs2, id_ex_valid, id_ex_mem_read;
   logic       ex_mem_reg_write, mem_wb_reg_write;

   logic        stall1, stall3;
   logic [1:0]  fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3;
   logic [31:0] sc1, sc3;

   int pass_cnt = 0;
   int total_cnt = 0;

   longint cyc;
   longint last_issue [32];
   int     esc1, esc3;

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rd(id_ex_rd), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
      .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .stall(stall1), .forward_a(fa1), .forward_b(fb1),
      .forward_rs1_decode(fd1_1), .forward_rs2_decode(fd2_1), .stall_count(sc1)
   );

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rd(id_ex_rd), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
      .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .stall(stall3), .forward_a(fa3), .forward_b(fb3),
      .forward_rs1_decode(fd1_3), .forward_rs2_decode(fd2_3), .stall_count(sc3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_busy(input int lat, input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (id_ex_valid && id_ex_mem_read && id_ex_rd == r) return 1'b1;
      return cyc < last_issue[r] + longint'(lat);
   endfunction

   function automatic bit m_stall(input int lat);
      return (if_id_use_rs1 && m_busy(lat, if_id_rs1)) || (if_id_use_rs2 && m_busy(lat, if_id_rs2));
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] s);
      if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == s) return 2'b01;
      if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == s) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_sc(input int n);
`ifdef HAZARD_PERF_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic clear_inputs();
      if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0;
      id_ex_valid = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
      id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
      ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) last_issue[r] = -1000;
      esc1 = 0;
      esc3 = 0;
   endtask

   // Advance one clock and let the model absorb the edge with the inputs that were present.
   task automatic tick();
      bit s1, s3;
      s1 = m_stall(1);
      s3 = m_stall(3);
      @(posedge clk);
      if (s1) esc1++;
      if (s3) esc3++;
      if (id_ex_valid && id_ex_mem_read && id_ex_rd != 5'd0) last_issue[id_ex_rd] = cyc;
      cyc++;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      total_cnt++;
      if ({stall1, stall3, fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3} !== 18'd0) begin
         $display("FAIL reset_outputs got=%h exp=0",
                  {stall1, stall3, fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3});
      end else pass_cnt++;
      total_cnt++;
      if (sc1 !== 32'd0 || sc3 !== 32'd0) $display("FAIL reset_count got=%0d/%0d exp=0", sc1, sc3);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_load_use_lat1();
      apply_reset();
      id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
      if_id_rs1 = 5'd5; if_id_use_rs1 = 1'b1; if_id_rs2 = 5'd1; if_id_use_rs2 = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (stall1 !== 1'b1) $display("FAIL lat1_stall got=%b exp=1", stall1); else pass_cnt++;
      tick();
      id_ex_valid = 1'b0; id_ex_mem_read = 1'b0; ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (stall1 !== 1'b0) $display("FAIL lat1_release got=%b exp=0", stall1); else pass_cnt++;
      tick();
      id_ex_valid = 1'b1; id_ex_rd = 5'd6; id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd1;
      ex_mem_reg_write = 1'b0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1;
      if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (fa1 !== 2'b10 || fb1 !== 2'b00) $display("FAIL lat1_fwd got=%b/%b exp=10/00", fa1, fb1);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_lat3_stall();
      int n1, n3;
      apply_reset();
      n1 = 0; n3 = 0;
      id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd7;
      if_id_rs1 = 5'd7; if_id_use_rs1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (stall1 === 1'b1) n1++;
         if (stall3 === 1'b1) n3++;
         total_cnt++;
         if (stall3 !== (c < 3)) $display("FAIL lat3_stall_c%0d got=%b exp=%b", c, stall3, c < 3);
         else pass_cnt++;
         tick();
         id_ex_valid = 1'b0; id_ex_mem_read = 1'b0;
      end
      total_cnt++;
      if (n1 != 1 || n3 != 3) $display("FAIL lat3_len got=%0d/%0d exp=1/3", n1, n3); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (sc1 !== m_sc(1) || sc3 !== m_sc(3))
         $display("FAIL stall_count got=%0d/%0d exp=%0d/%0d", sc1, sc3, m_sc(1), m_sc(3));
      else pass_cnt++;
      tick();
   endtask

   task automatic test_x0();
      apply_reset();
      id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd0;
      if_id_use_rs1 = 1'b1; if_id_use_rs2 = 1'b1;
      ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({stall1, stall3, fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3} !== 18'd0)
            $display("FAIL x0_c%0d got=%h exp=0", c,
                     {stall1, stall3, fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3});
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_forward_priority();
      apply_reset();
      ex_mem_rd = 5'd3; mem_wb_rd = 5'd3; ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
      id_ex_rs1 = 5'd3; id_ex_rs2 = 5'd2; if_id_rs2 = 5'd3; if_id_use_rs2 = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (fa3 !== 2'b01 || fb3 !== 2'b00 || fd2_3 !== 2'b01)
         $display("FAIL fwd_prio got=%b/%b/%b exp=01/00/01", fa3, fb3, fd2_3);
      else pass_cnt++;
      ex_mem_reg_write = 1'b0;
      if_id_use_rs2 = 1'b0;
      #1;
      total_cnt++;
      if (fa1 !== 2'b10 || fd2_1 !== 2'b00)
         $display("FAIL fwd_memwb got=%b/%b exp=10/00", fa1, fd2_1);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reload();
      int n3;
      apply_reset();
      n3 = 0;
      id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd4;
      @(negedge clk);
      total_cnt++;
      if (stall3 !== 1'b0) $display("FAIL reload_first got=%b exp=0", stall3); else pass_cnt++;
      tick();
      if_id_rs2 = 5'd4; if_id_use_rs2 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (stall3 === 1'b1) n3++;
         tick();
         id_ex_valid = 1'b0; id_ex_mem_read = 1'b0;
      end
      total_cnt++;
      if (n3 != 3) $display("FAIL reload_len got=%0d exp=3", n3); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd9;
      tick();
      id_ex_valid = 1'b0; id_ex_mem_read = 1'b0;
      if_id_rs1 = 5'd9; if_id_use_rs1 = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (stall3 !== 1'b1) $display("FAIL midstall_pre got=%b exp=1", stall3); else pass_cnt++;
      #1 reset = 1'b1;
      #1;
      total_cnt++;
      if (stall3 !== 1'b0 || sc3 !== 32'd0)
         $display("FAIL midstall_async got=%b/%0d exp=0/0", stall3, sc3);
      else pass_cnt++;
      #1 reset = 1'b0;
      model_reset();
      #1;
      total_cnt++;
      if (stall3 !== 1'b0) $display("FAIL midstall_cleared got=%b exp=0", stall3); else pass_cnt++;
      tick();
   endtask

   task automatic test_random();
      logic [81:0] got, exp;
      int errs;
      apply_reset();
      errs = 0;
      for (int c = 0; c < 400; c++) begin
         if_id_rs1 = 5'($urandom_range(0, 7)); if_id_rs2 = 5'($urandom_range(0, 7));
         if_id_use_rs1 = 1'($urandom); if_id_use_rs2 = 1'($urandom);
         id_ex_valid = ($urandom_range(0, 3) != 0); id_ex_mem_read = 1'($urandom);
         id_ex_rd = 5'($urandom_range(0, 7));
         id_ex_rs1 = 5'($urandom_range(0, 7)); id_ex_rs2 = 5'($urandom_range(0, 7));
         ex_mem_rd = 5'($urandom_range(0, 7)); mem_wb_rd = 5'($urandom_range(0, 7));
         ex_mem_reg_write = 1'($urandom); mem_wb_reg_write = 1'($urandom);
         @(negedge clk);
         got = {stall1, stall3, fa1, fb1, fd1_1, fd2_1, fa3, fb3, fd1_3, fd2_3, sc1, sc3};
         exp = {m_stall(1), m_stall(3),
                m_fwd(id_ex_rs1), m_fwd(id_ex_rs2),
                if_id_use_rs1 ? m_fwd(if_id_rs1) : 2'b00, if_id_use_rs2 ? m_fwd(if_id_rs2) : 2'b00,
                m_fwd(id_ex_rs1), m_fwd(id_ex_rs2),
                if_id_use_rs1 ? m_fwd(if_id_rs1) : 2'b00, if_id_use_rs2 ? m_fwd(if_id_rs2) : 2'b00,
                m_sc(esc1), m_sc(esc3)};
         total_cnt++;
         if (got !== exp) begin
            if (errs < 10) $display("FAIL random_c%0d got=%h exp=%h", c, got, exp);
            errs++;
         end else pass_cnt++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      cyc = 0;
      clear_inputs();
      model_reset();
      test_reset();
      test_load_use_lat1();
      test_lat3_stall();
      test_x0();
      test_forward_priority();
      test_reload();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
